// File: rtl/ay_pwm_decode.sv
// ay_pwm_decode: recovers the duty count and AY amplitude code from a PWM stream.
// Define AY_PWM_DECODE_AVG_EN to report the rounded-up mean of the last two frames.
module ay_pwm_decode #(
    parameter int FRAME_LEN   = 111,
    parameter int SLACK       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pwm_in,
    output logic                           valid,
    output logic [$clog2(FRAME_LEN+1)-1:0] duty,
    output logic [3:0]                     amp,
    output logic                           frame_err,
    output logic                           locked
);
    localparam int DW      = $clog2(FRAME_LEN + 1);
    localparam int CW      = $clog2(FRAME_LEN + SLACK + 1);
    localparam int TIMEOUT = FRAME_LEN + SLACK;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_MEAS  = 2'd1,
        ST_CONST = 2'd2
    } state_t;

    function automatic int ay_level(input int k);
        int lvl;
        case (k)
            8:       lvl = 10;
            9:       lvl = 14;
            10:      lvl = 17;
            11:      lvl = 28;
            12:      lvl = 34;
            13:      lvl = 56;
            14:      lvl = 79;
            15:      lvl = 111;
            default: lvl = k;
        endcase
        return lvl;
    endfunction

    function automatic logic [DW-1:0] amp_thresh(input int k);
        return DW'((ay_level(k) * FRAME_LEN) / 111);
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    logic                   s;
    logic                   rise;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, hi_q, hi_d;
    logic [CW-1:0] cnt_inc, hi_inc;
    logic          timeout, frame_tick;
    logic          close_frame, level_strobe;
    logic [DW-1:0] frame_duty, level_duty;
    logic          frame_bad;

    logic          valid_q, valid_d;
    logic [DW-1:0] duty_q, duty_d;
    logic [3:0]    amp_q, amp_d;
    logic          err_q, err_d;
    logic          locked_q, locked_d;

`ifdef AY_PWM_DECODE_AVG_EN
    logic          have_prev_q, have_prev_d;
    logic [DW-1:0] prev_duty_q, prev_duty_d;
    logic          prev_err_q, prev_err_d;
    logic [DW:0]   avg_sum;
    assign avg_sum = {1'b0, prev_duty_q} + {1'b0, frame_duty} + (DW+1)'(1);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_d_q  <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;

    assign timeout    = (cnt_q == CW'(TIMEOUT));
    assign frame_tick = (cnt_q == CW'(FRAME_LEN));
    assign cnt_inc    = timeout ? cnt_q : cnt_q + CW'(1);
    assign hi_inc     = (hi_q == CW'(TIMEOUT)) ? hi_q : hi_q + CW'(s);
    assign frame_duty = (hi_q > CW'(FRAME_LEN)) ? DW'(FRAME_LEN) : hi_q[DW-1:0];
    assign frame_bad  = (cnt_q != CW'(FRAME_LEN));
    assign level_duty = s ? DW'(FRAME_LEN) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // A rising edge always beats the timeout when both land on the same clock.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HUNT, ST_MEAS: begin
                if (rise) begin
                    state_d = ST_MEAS;
                end else if (timeout) begin
                    state_d = ST_CONST;
                end
            end
            ST_CONST: begin
                if (rise) begin
                    state_d = ST_MEAS;
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_inc;
        hi_d         = hi_q;
        close_frame  = 1'b0;
        level_strobe = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (rise) begin
                    cnt_d = CW'(1);
                    hi_d  = CW'(1);
                end else if (timeout) begin
                    level_strobe = 1'b1;
                    cnt_d        = CW'(1);
                end
            end
            ST_MEAS: begin
                if (rise) begin
                    close_frame = 1'b1;
                    cnt_d       = CW'(1);
                    hi_d        = CW'(1);
                end else if (timeout) begin
                    level_strobe = 1'b1;
                    cnt_d        = CW'(1);
                end else begin
                    hi_d = hi_inc;
                end
            end
            ST_CONST: begin
                if (rise) begin
                    cnt_d = CW'(1);
                    hi_d  = CW'(1);
                end else if (frame_tick) begin
                    level_strobe = 1'b1;
                    cnt_d        = CW'(1);
                end
            end
            default: begin
                cnt_d = '0;
                hi_d  = '0;
            end
        endcase

        valid_d  = 1'b0;
        duty_d   = duty_q;
        err_d    = err_q;
        locked_d = locked_q;
`ifdef AY_PWM_DECODE_AVG_EN
        have_prev_d = have_prev_q;
        prev_duty_d = prev_duty_q;
        prev_err_d  = prev_err_q;
`endif
        if (level_strobe) begin
            valid_d  = 1'b1;
            duty_d   = level_duty;
            err_d    = 1'b0;
            locked_d = 1'b1;
`ifdef AY_PWM_DECODE_AVG_EN
            have_prev_d = 1'b0;
`endif
        end else if (close_frame) begin
`ifdef AY_PWM_DECODE_AVG_EN
            have_prev_d = 1'b1;
            prev_duty_d = frame_duty;
            prev_err_d  = frame_bad;
            if (have_prev_q) begin
                valid_d  = 1'b1;
                duty_d   = avg_sum[DW:1];
                err_d    = prev_err_q | frame_bad;
                locked_d = ~(prev_err_q | frame_bad);
            end
`else
            valid_d  = 1'b1;
            duty_d   = frame_duty;
            err_d    = frame_bad;
            locked_d = ~frame_bad;
`endif
        end
    end

    // Inverse amplitude table: one threshold compare per code, highest passing code wins.
    logic [15:0] code_ge;
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_thresh
            localparam logic [DW-1:0] TH = amp_thresh(gi);
            assign code_ge[gi] = (duty_d >= TH);
        end
    endgenerate

    always_comb begin
        amp_d = '0;
        for (int k = 0; k < 16; k++) begin
            if (code_ge[k]) begin
                amp_d = 4'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            valid_q  <= 1'b0;
            duty_q   <= '0;
            amp_q    <= '0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
`ifdef AY_PWM_DECODE_AVG_EN
            have_prev_q <= 1'b0;
            prev_duty_q <= '0;
            prev_err_q  <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            valid_q  <= valid_d;
            duty_q   <= duty_d;
            amp_q    <= amp_d;
            err_q    <= err_d;
            locked_q <= locked_d;
`ifdef AY_PWM_DECODE_AVG_EN
            have_prev_q <= have_prev_d;
            prev_duty_q <= prev_duty_d;
            prev_err_q  <= prev_err_d;
`endif
        end
    end

    assign valid     = valid_q;
    assign duty      = duty_q;
    assign amp       = amp_q;
    assign frame_err = err_q;
    assign locked    = locked_q;

endmodule
